// File: rtl/seq_checker_sefunmi_if.sv
// Receiver-to-checker word bus plus the checker's status outputs.
// master drives valid/data; slave is the checker that produces the status.
interface seq_checker_sefunmi_if #(
   parameter int WIDTH     = 9,
   parameter int CNT_WIDTH = 8
);
   logic                 data_valid;
   logic [WIDTH-1:0]     data_received;
   logic                 locked;
   logic                 word_ok;
   logic                 word_err;
   logic [CNT_WIDTH-1:0] good_count;
   logic [CNT_WIDTH-1:0] err_count;
   logic [WIDTH-1:0]     last_word;

   modport master (
      output data_valid, data_received,
      input  locked, word_ok, word_err, good_count, err_count, last_word
   );

   modport slave (
      input  data_valid, data_received,
      output locked, word_ok, word_err, good_count, err_count, last_word
   );
endinterface

// File: rtl/seq_checker_sefunmi.sv
// Checks received words form a contiguous incrementing count; tracks lock, tallies good/bad words.
// Latency: one edge from a sampled word to pulses, counters, last_word and locked.
// No backpressure: every valid word is accepted; data_valid low cycles are transparent.
module seq_checker_sefunmi #(
   parameter int WIDTH      = 9,
   parameter int SYNC_COUNT = 4,
   parameter int ERR_LIMIT  = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 clr,
   seq_checker_sefunmi_if.slave bus
);
   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      SYNC   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0] SYNC_N = 4'(SYNC_COUNT);
   localparam logic [3:0] ERR_N  = 4'(ERR_LIMIT);

   state_t               state;
   logic [WIDTH-1:0]     exp_word;
   logic [WIDTH-1:0]     last_q;
   logic [3:0]           run;
   logic [3:0]           miss;
   logic                 locked_q;
   logic                 ok_q;
   logic                 err_q;
   logic [CNT_WIDTH-1:0] good_q;
   logic [CNT_WIDTH-1:0] bad_q;

   logic                 match;
   logic [3:0]           run_inc;
   logic [3:0]           miss_inc;
   logic [WIDTH-1:0]     word_inc;

   assign match    = (bus.data_received == exp_word);
   assign run_inc  = run + 4'd1;
   assign miss_inc = miss + 4'd1;
   assign word_inc = bus.data_received + WIDTH'(1);

   always_ff @(posedge clk) begin
      if (clr) begin
         state    <= HUNT;
         exp_word <= '0;
         run      <= '0;
         miss     <= '0;
         locked_q <= 1'b0;
         ok_q     <= 1'b0;
         err_q    <= 1'b0;
         good_q   <= '0;
         bad_q    <= '0;
         last_q   <= '0;
      end else begin
         ok_q  <= 1'b0;
         err_q <= 1'b0;
         if (bus.data_valid) begin
            last_q <= bus.data_received;
            case (state)
               HUNT: begin
                  exp_word <= word_inc;
                  run      <= 4'd1;
                  state    <= SYNC;
               end
               SYNC: begin
                  exp_word <= word_inc;
                  if (match) begin
                     run <= run_inc;
                     if (run_inc == SYNC_N) begin
                        state    <= LOCKED;
                        locked_q <= 1'b1;
                        miss     <= '0;
                     end
                  end else begin
                     run <= 4'd1;
                  end
               end
               LOCKED: begin
                  // Flywheel: expectation advances on hits and misses alike
                  exp_word <= exp_word + WIDTH'(1);
                  if (match) begin
                     ok_q <= 1'b1;
                     miss <= '0;
                     if (good_q != '1) good_q <= good_q + CNT_WIDTH'(1);
                  end else begin
                     err_q <= 1'b1;
                     miss  <= miss_inc;
                     if (bad_q != '1) bad_q <= bad_q + CNT_WIDTH'(1);
                     if (miss_inc == ERR_N) begin
                        state    <= HUNT;
                        locked_q <= 1'b0;
                     end
                  end
               end
               default: begin
                  state    <= HUNT;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.locked     = locked_q;
   assign bus.word_ok    = ok_q;
   assign bus.word_err   = err_q;
   assign bus.good_count = good_q;
   assign bus.err_count  = bad_q;
   assign bus.last_word  = last_q;
endmodule

// File: doc/seq_checker_sefunmi.md
# seq_checker_sefunmi

Downstream consumer of the channel receiver. It samples each word that the receiver flags with `data_valid` and checks that the words arrive as a contiguous incrementing count, matching what the counter-driven transmitter produces. It acquires and tracks lock on that sequence, flags every good or bad word with a one-cycle pulse, and keeps saturating good and error tallies for the channel bench and for board-level status display.

## Interface
- `WIDTH`, default 9: data word width; matches the receiver's `data_received`.
- `SYNC_COUNT`, default 4: number of consecutive in-sequence words needed to lock (legal range 2..15).
- `ERR_LIMIT`, default 8: number of consecutive mismatches in LOCKED that drop lock (legal range 1..15).
- `CNT_WIDTH`, default 8: width of `good_count` and `err_count`.
- `clk`  in  1: system clock; all logic is on the rising edge.
- `clr`  in  1: synchronous, active-high reset.
- `data_valid`  in  1: the word on `data_received` is new this cycle. Sampled only when high.
- `data_received`  in  WIDTH: word from the receiver.
- `locked`  out  1: high while the FSM is in LOCKED.
- `word_ok`  out  1: one-cycle pulse marking an in-sequence word seen while LOCKED.
- `word_err`  out  1: one-cycle pulse marking an out-of-sequence word seen while LOCKED.
- `good_count`  out  CNT_WIDTH: saturating count of `word_ok` events.
- `err_count`  out  CNT_WIDTH: saturating count of `word_err` events.
- `last_word`  out  WIDTH: last sampled word.

## Operation
- Internal state:
  - 3-state FSM: HUNT, SYNC, LOCKED.
  - Expected-word register `exp` (WIDTH bits).
  - Match run counter `run` (4 bits).
  - Miss run counter `miss` (4 bits).
- A match means `data_received == exp`.
- All increments of `exp` are modulo 2^WIDTH, so 511 followed by 0 is a match.
- Cycles with `data_valid` low change nothing: no pulses, no counter or state updates, and `exp` holds. Transmitter pauses are therefore transparent.
- Every valid word updates `last_word`.
- HUNT, on a valid word:
  - `exp` <= word+1
  - `run` <= 1
  - go to SYNC
- SYNC, on a valid word that matches:
  - `exp` <= word+1
  - `run` <= `run`+1
  - if `run`+1 == SYNC_COUNT, go to LOCKED with `miss` <= 0
- SYNC, on a valid word that mismatches: restart acquisition on this word (`exp` <= word+1, `run` <= 1) and stay in SYNC.
- LOCKED, on a valid word that matches:
  - pulse `word_ok`
  - `good_count` +1, saturating
  - `miss` <= 0
  - `exp` <= `exp`+1
- LOCKED, on a valid word that mismatches:
  - pulse `word_err`
  - `err_count` +1, saturating
  - `exp` <= `exp`+1 (flywheel: the expected value keeps advancing)
  - `miss` <= `miss`+1
  - if `miss`+1 == ERR_LIMIT, go to HUNT
- No pulses are produced outside LOCKED. The word that completes lock produces no pulse and is not counted.
- Both counters saturate at all-ones and hold there until `clr`.
- A transmitter clear (the count restarts at 0) appears as mismatches. Lock is lost after ERR_LIMIT of them and the checker reacquires from HUNT.

## Timing
- All outputs are registered.
- Latency: a word sampled on edge N is reflected on `word_ok`/`word_err`, the counters, `last_word` and `locked` after edge N. Each pulse is exactly one cycle wide.
- Back-to-back valid words (one per cycle) are supported at full rate. Consecutive pulses may therefore be contiguous.
- `clr` high at an edge forces:
  - FSM to HUNT
  - `exp`, `run`, `miss` to 0
  - `locked`, `word_ok`, `word_err` to 0
  - `good_count`, `err_count`, `last_word` to 0
- `clr` dominates `data_valid` in the same cycle; the word is discarded.
- Reset mid-lock takes effect at the next edge. The following valid word is treated as a fresh HUNT word.
- `locked` falls in the same cycle as the `word_err` pulse for the ERR_LIMIT-th consecutive miss.

## Test plan
- Lock acquisition: after `clr`, send valid words 5,6,7,8 back-to-back.
  - `locked` rises after the edge sampling 8.
  - No pulses during acquisition; both counters stay 0.
  - Then send 9,10: two `word_ok` pulses; `good_count`=2.
- Sync restart: send 3,4,20,21,22,23.
  - The mismatch at 20 restarts acquisition.
  - `locked` rises only after 23; no pulses.
- Wrap and gaps: lock on 508..511, then send 0 and 1 with 3 idle cycles between valid words.
  - Two `word_ok` pulses; `locked` stays 1.
  - No activity during the idle cycles.
- Flywheel and loss of lock: while locked expecting 40, send 0,1,...,7 (a simulated transmitter clear).
  - Eight `word_err` pulses; `err_count`=8.
  - `locked` falls with the 8th pulse.
  - Then send 8,9,10,11: relock after 11.
- Single glitch: while locked expecting 50, send 50,99,52,53.
  - `word_ok`, `word_err`, `word_ok`, `word_ok` in that order (flywheel keeps the expected sequence).
  - `locked` stays 1.
- Saturation and reset: with CNT_WIDTH=4, send 20 in-sequence words while locked.
  - `good_count` holds at 15.
  - Assert `clr` in the same cycle as a valid word: all outputs are 0 the next cycle and the word is ignored.
